// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter fed by the core's 9-bit uart_out strobe.
// A circular FIFO absorbs store bursts; frames are sent back-to-back.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int AW           = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [8:0]    uart_in,
  output logic          tx,
  output logic          ready,
  output logic          busy,
  output logic          overflow,
  output logic [AW:0]   level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] baud;
  logic [CW-1:0] baud_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic          tx_n;

  logic          full;
  logic          bit_end;
  logic          pop;
  logic          push;

  assign full    = (count == DEPTH);
  assign bit_end = (baud == BAUD_MAX);
  // A full FIFO still accepts a strobe when the head leaves this cycle
  assign push    = uart_in[8] & (~full | pop);

  assign ready = ~full;
  assign busy  = (state != IDLE) | (count != '0);
  assign level = count;

  always_comb begin
    state_n   = state;
    baud_n    = bit_end ? '0 : baud + 1'b1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
          tx_n      = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            shift_n   = shift >> 1;
            tx_n      = shift[1];
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (count != '0) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (uart_in[8] & ~push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= uart_in[7:0];
  end

endmodule
